prog_sequencer: RTL

Multi-cycle program sequencer that drives the program counter and instruction-fetch phases of the microprocessor. It replaces the free-running counter load path with a FETCH/EXECUTE state machine, resolves jump, conditional jump, call and return, and keeps a small hardware return-address stack. Its outputs feed the instruction ROM address, the instruction register enable and the datapath execute enable.

---
 rtl/prog_sequencer_pkg.sv | 17 +
 rtl/prog_sequencer_ret_stack.sv | 62 ++++++
 rtl/prog_sequencer.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/prog_sequencer_pkg.sv
// Shared definitions for the program sequencer.
//   state_t          : FSM encoding (IDLE/FETCH/EXEC/HALT)
//   DEF_BIT_WIDTH    : default program-address width
//   DEF_STACK_DEPTH  : default return-stack depth
package prog_sequencer_pkg;

  localparam int unsigned DEF_BIT_WIDTH   = 4;
  localparam int unsigned DEF_STACK_DEPTH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    FETCH = 2'b01,
    EXEC  = 2'b10,
    HALT  = 2'b11
  } state_t;

endpackage

// File: rtl/prog_sequencer_ret_stack.sv
// Return-address LIFO for the program sequencer.
//   clk, rst     : clock, asynchronous active-low reset
//   clear        : synchronous empty (used while the sequencer is idle)
//   push, pop    : push_data is written on push; pop_data is the current top
//   full, empty  : occupancy flags; push when full / pop when empty are ignored
//   depth        : number of stored entries, 0..DEPTH
module ret_stack
  import prog_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH    = DEF_BIT_WIDTH,
  parameter int unsigned DEPTH    = DEF_STACK_DEPTH,
  parameter int unsigned SP_WIDTH = $clog2(DEF_STACK_DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic                push,
  input  logic                pop,
  input  logic [WIDTH-1:0]    push_data,
  output logic [WIDTH-1:0]    pop_data,
  output logic                full,
  output logic                empty,
  output logic [SP_WIDTH:0]   depth
);

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [SP_WIDTH:0] count;
  logic [SP_WIDTH-1:0] wr_idx;
  logic [SP_WIDTH-1:0] rd_idx;
  logic do_push;
  logic do_pop;

  // Low bits of the count address the next free slot; the top entry sits one below.
  assign wr_idx  = count[SP_WIDTH-1:0];
  assign rd_idx  = wr_idx - 1'b1;
  assign full    = (count == (SP_WIDTH+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full && !clear;
  assign do_pop  = pop && !empty && !clear;

  assign pop_data = mem[rd_idx];
  assign depth    = count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (do_push) begin
      count <= count + 1'b1;
    end else if (do_pop) begin
      count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_idx] <= push_data;
    end
  end

endmodule

// File: rtl/prog_sequencer.sv
// Program sequencer: FETCH/EXEC state machine, program counter and
// next-pc priority mux with a hardware return-address stack.
//   clk, rst        : clock, asynchronous active-low reset
//   run             : host start/enable level
//   target          : jump/call destination of the current instruction
//   halt_inst .. ret_inst, alu_cout : decoded instruction class, used in EXEC only
//   pc              : program counter / ROM address
//   fetch_en        : instruction-register load enable (FETCH)
//   exec_en         : datapath execute enable (EXEC)
//   halted          : high in HALT
//   stack_err       : sticky stack overflow/underflow flag, cleared on start
//   stack_depth     : current return-stack occupancy
module prog_sequencer
  import prog_sequencer_pkg::*;
#(
  parameter int unsigned BIT_WIDTH   = DEF_BIT_WIDTH,
  parameter int unsigned STACK_DEPTH = DEF_STACK_DEPTH,
  parameter int unsigned SP_WIDTH    = $clog2(STACK_DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run,
  input  logic [BIT_WIDTH-1:0] target,
  input  logic                 halt_inst,
  input  logic                 jmp_inst,
  input  logic                 cjmp_inst,
  input  logic                 call_inst,
  input  logic                 ret_inst,
  input  logic                 alu_cout,
  output logic [BIT_WIDTH-1:0] pc,
  output logic                 fetch_en,
  output logic                 exec_en,
  output logic                 halted,
  output logic                 stack_err,
  output logic [SP_WIDTH:0]    stack_depth
);

  state_t state, state_next;
  logic [BIT_WIDTH-1:0] pc_next;
  logic [BIT_WIDTH-1:0] pc_inc;
  logic [BIT_WIDTH-1:0] pop_data;
  logic push, pop, clear;
  logic full, empty;
  logic err_set, err_clr;

  // Natural modulo-2^BIT_WIDTH wrap for both sequential flow and return address.
  assign pc_inc = pc + 1'b1;

  ret_stack #(
    .WIDTH    (BIT_WIDTH),
    .DEPTH    (STACK_DEPTH),
    .SP_WIDTH (SP_WIDTH)
  ) u_stack (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .push      (push),
    .pop       (pop),
    .push_data (pc_inc),
    .pop_data  (pop_data),
    .full      (full),
    .empty     (empty),
    .depth     (stack_depth)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      pc        <= '0;
      stack_err <= 1'b0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      if (err_clr) begin
        stack_err <= 1'b0;
      end else if (err_set) begin
        stack_err <= 1'b1;
      end
    end
  end

  always_comb begin
    state_next = state;
    pc_next    = pc;
    push       = 1'b0;
    pop        = 1'b0;
    clear      = 1'b0;
    err_set    = 1'b0;
    err_clr    = 1'b0;
    unique case (state)
      IDLE: begin
        pc_next = '0;
        clear   = 1'b1;
        if (run) begin
          state_next = FETCH;
          err_clr    = 1'b1;
        end
      end
      FETCH: begin
        state_next = EXEC;
      end
      EXEC: begin
        // Priority: halt > ret > call > jmp > taken cjmp > sequential.
        if (halt_inst) begin
          state_next = HALT;
        end else if (ret_inst) begin
          if (empty) begin
            err_set    = 1'b1;
            state_next = HALT;
          end else begin
            pop        = 1'b1;
            pc_next    = pop_data;
            state_next = FETCH;
          end
        end else if (call_inst) begin
          if (full) begin
            err_set    = 1'b1;
            state_next = HALT;
          end else begin
            push       = 1'b1;
            pc_next    = target;
            state_next = FETCH;
          end
        end else if (jmp_inst || (cjmp_inst && alu_cout)) begin
          pc_next    = target;
          state_next = FETCH;
        end else begin
          pc_next    = pc_inc;
          state_next = FETCH;
        end
      end
      HALT: begin
        if (!run) begin
          state_next = IDLE;
          pc_next    = '0;
          clear      = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign fetch_en = (state == FETCH);
  assign exec_en  = (state == EXEC);
  assign halted   = (state == HALT);

endmodule
